// File: rtl/aes128_pkg.sv
// ---------------------------------------------------------------------------
// aes128_pkg
// Shared types and sizes for the AES-128 block loader front end.
// ---------------------------------------------------------------------------
`default_nettype none

package aes128_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_WORD_W      = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WCNT_W          = $clog2(WORDS_PER_BLOCK);

  // Loader sequencing: key group, data group, start pulse, core wait, result hold.
  typedef enum logic [2:0] {
    LOAD_KEY  = 3'd0,
    LOAD_DATA = 3'd1,
    START     = 3'd2,
    WAIT      = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/aes128_word_packer.sv
// ---------------------------------------------------------------------------
// aes128_word_packer
// 32-to-128 assembly shift register with a 2-bit position counter.
// block_o is the 128-bit group as it will look once word_i is shifted in,
// so the owner can load it into the key or data register on the transfer.
// ---------------------------------------------------------------------------
`default_nettype none

module aes128_word_packer
  import aes128_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AES_WORD_W-1:0]  word_i,
  input  logic                   xfer_i,
  output logic [AES_BLOCK_W-1:0] block_o,
  output logic                   first_o,
  output logic                   last_o
);

  // Only the three most recent words need storing; the fourth is word_i itself.
  logic [AES_BLOCK_W-AES_WORD_W-1:0] hist_q, hist_d;
  logic [WCNT_W-1:0]                 cnt_q, cnt_d;

  assign block_o = {hist_q, word_i};
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == WCNT_W'(WORDS_PER_BLOCK - 1));

  // Shift and count on every accepted word; the counter wraps to 0 after a full group.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (xfer_i) begin
      hist_d = block_o[AES_BLOCK_W-AES_WORD_W-1:0];
      cnt_d  = cnt_q + WCNT_W'(1);
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes128_block_loader.sv
// ---------------------------------------------------------------------------
// aes128_block_loader
// Streams key and plaintext words into 128-bit core buses, pulses the core
// start, waits CORE_LATENCY cycles, captures the result and hands it out
// over a valid/ready handshake. One block in flight at a time.
// Optional: AES128_LOADER_KEY_REUSE_EN lets a job flagged with pi_keep_key
// skip the key group when a valid key is already loaded.
// ---------------------------------------------------------------------------
`default_nettype none

module aes128_block_loader
  import aes128_pkg::*;
#(
  parameter  int CORE_LATENCY = 44,
  localparam int CNT_W        = $clog2(CORE_LATENCY + 1)
) (
  input  logic                   pi_clk,
  input  logic                   pi_rst,
  input  logic [AES_WORD_W-1:0]  pi_word,
  input  logic                   pi_word_valid,
  output logic                   po_word_ready,
  input  logic                   pi_keep_key,
  output logic [AES_BLOCK_W-1:0] po_input_key,
  output logic [AES_BLOCK_W-1:0] po_input_data,
  output logic                   po_start,
  input  logic [AES_BLOCK_W-1:0] pi_core_out,
  output logic [AES_BLOCK_W-1:0] po_cipher,
  output logic                   po_cipher_valid,
  input  logic                   pi_cipher_ready,
  output logic                   po_busy
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [AES_BLOCK_W-1:0] cipher_q, cipher_d;
  logic                   cvalid_q, cvalid_d;
  logic                   key_valid_q, key_valid_d;

  logic                   w_load;
  logic                   w_xfer;
  logic [AES_BLOCK_W-1:0] w_block;
  logic                   w_first;
  logic                   w_last;
  logic                   w_reuse;

  // Ready is masked during reset so every output reads 0 while pi_rst is high.
  assign w_load        = (state_q == LOAD_KEY) || (state_q == LOAD_DATA);
  assign po_word_ready = w_load && !pi_rst;
  assign w_xfer        = pi_word_valid && po_word_ready;

  aes128_word_packer u_packer (
    .clk_i   (pi_clk),
    .rst_i   (pi_rst),
    .word_i  (pi_word),
    .xfer_i  (w_xfer),
    .block_o (w_block),
    .first_o (w_first),
    .last_o  (w_last)
  );

`ifdef AES128_LOADER_KEY_REUSE_EN
  // First word of a job flagged keep-key becomes data word 0 when a key is loaded.
  assign w_reuse = (state_q == LOAD_KEY) && w_first && pi_keep_key && key_valid_q;
`else
  logic unused_reuse_inputs;
  assign unused_reuse_inputs = ^{pi_keep_key, key_valid_q, w_first};
  assign w_reuse = 1'b0;
`endif

  assign po_input_key    = key_q;
  assign po_input_data   = data_q;
  assign po_cipher       = cipher_q;
  assign po_cipher_valid = cvalid_q;

  // Next-state, datapath steering and strobe outputs.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    key_d       = key_q;
    data_d      = data_q;
    cipher_d    = cipher_q;
    cvalid_d    = cvalid_q;
    key_valid_d = key_valid_q;
    po_start    = 1'b0;
    po_busy     = 1'b0;
    case (state_q)
      LOAD_KEY: begin
        if (w_xfer) begin
          if (w_reuse) begin
            data_d  = w_block;
            state_d = LOAD_DATA;
          end else begin
            key_d = w_block;
            if (w_last) begin
              key_valid_d = 1'b1;
              state_d     = LOAD_DATA;
            end
          end
        end
      end
      LOAD_DATA: begin
        if (w_xfer) begin
          data_d = w_block;
          if (w_last) begin
            state_d = START;
          end
        end
      end
      START: begin
        po_start = 1'b1;
        po_busy  = 1'b1;
        lat_d    = CNT_W'(1);
        state_d  = WAIT;
      end
      WAIT: begin
        po_busy = 1'b1;
        // Counter equals cycles elapsed since the start pulse; it stops at the sample point.
        if (lat_q == CNT_W'(CORE_LATENCY)) begin
          cipher_d = pi_core_out;
          cvalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (pi_cipher_ready) begin
          cvalid_d = 1'b0;
          state_d  = LOAD_KEY;
        end
      end
      default: begin
        state_d = LOAD_KEY;
      end
    endcase
  end

  // Control and datapath registers; reset discards any in-flight job and the key.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      state_q     <= LOAD_KEY;
      lat_q       <= '0;
      key_q       <= '0;
      data_q      <= '0;
      cipher_q    <= '0;
      cvalid_q    <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      key_q       <= key_d;
      data_q      <= data_d;
      cipher_q    <= cipher_d;
      cvalid_q    <= cvalid_d;
      key_valid_q <= key_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes128_block_loader.sv
// ---------------------------------------------------------------------------
// tb_aes128_block_loader
// Bench for aes128_block_loader with a fake core that only presents the
// right answer in the exact sample cycle.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes128_block_loader;

  localparam int L = 44;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         pi_rst = 1'b1;
  logic [31:0]  pi_word = '0;
  logic         pi_word_valid = 1'b0;
  logic         po_word_ready;
  logic         pi_keep_key = 1'b0;
  logic [127:0] po_input_key, po_input_data;
  logic         po_start;
  logic [127:0] pi_core_out = '0;
  logic [127:0] po_cipher;
  logic         po_cipher_valid;
  logic         pi_cipher_ready = 1'b0;
  logic         po_busy;

  always #5 clk = ~clk;

  aes128_block_loader #(.CORE_LATENCY(L)) dut (
    .pi_clk          (clk),
    .pi_rst          (pi_rst),
    .pi_word         (pi_word),
    .pi_word_valid   (pi_word_valid),
    .po_word_ready   (po_word_ready),
    .pi_keep_key     (pi_keep_key),
    .po_input_key    (po_input_key),
    .po_input_data   (po_input_data),
    .po_start        (po_start),
    .pi_core_out     (pi_core_out),
    .po_cipher       (po_cipher),
    .po_cipher_valid (po_cipher_valid),
    .pi_cipher_ready (pi_cipher_ready),
    .po_busy         (po_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the AES core: FIPS-197 vector, otherwise an arbitrary mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == FK && d == FD) return FC;
    return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  logic [31:0]  mq[$];
  int           job_len = 8;
  longint       t_start = -1;
  logic [127:0] m_key = '0, m_data = '0, m_exp = '0, m_cipher = '0;
  bit           m_kv = 1'b0;
  int           starts = 0;
  bit           er, es, eb, ev;

  always @(negedge clk) begin
    if (pi_rst) begin
      mq.delete();
      job_len  = 8;
      t_start  = -1;
      m_key    = '0;
      m_data   = '0;
      m_cipher = '0;
      m_kv     = 1'b0;
    end else begin
      er = (t_start < 0);
      es = (t_start >= 0) && (cyc == t_start);
      eb = (t_start >= 0) && (cyc >= t_start) && (cyc <= t_start + L);
      ev = (t_start >= 0) && (cyc > t_start + L);
      chk("word_ready", po_word_ready, er);
      chk("start", po_start, es);
      chk("busy", po_busy, eb);
      chk("cipher_valid", po_cipher_valid, ev);
      chk("cipher", po_cipher, m_cipher);
      if (t_start >= 0) begin
        chk("input_key", po_input_key, m_key);
        chk("input_data", po_input_data, m_data);
      end
      if (po_start) starts++;
      // Advance the model to the next cycle.
      if (t_start >= 0 && cyc == t_start + L) m_cipher = m_exp;
      if (ev && pi_cipher_ready) t_start = -1;
      if (er && pi_word_valid) begin
        mq.push_back(pi_word);
        if (mq.size() == 1) begin
`ifdef AES128_LOADER_KEY_REUSE_EN
          job_len = (pi_keep_key && m_kv) ? 4 : 8;
`else
          job_len = 8;
`endif
        end
        if (mq.size() == job_len) begin
          if (job_len == 8) begin
            m_key  = {mq[0], mq[1], mq[2], mq[3]};
            m_data = {mq[4], mq[5], mq[6], mq[7]};
            m_kv   = 1'b1;
          end else begin
            m_data = {mq[0], mq[1], mq[2], mq[3]};
          end
          m_exp   = core_fn(m_key, m_data);
          t_start = cyc + 1;
          mq.delete();
        end
      end
    end
  end

  // ---------------- core and consumer drivers ----------------
  int rmode = 1;  // 0: never ready, 1: always ready, 2: random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (t_start >= 0 && cyc == t_start + L)
        pi_core_out = core_fn(po_input_key, po_input_data);
      else
        pi_core_out = {$urandom, $urandom, $urandom, $urandom};
      case (rmode)
        0:       pi_cipher_ready = 1'b0;
        1:       pi_cipher_ready = 1'b1;
        default: pi_cipher_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic keep);
    int  n;
    bit  took;
    n = 0;
    took = 1'b0;
    pi_word = w;
    pi_keep_key = keep;
    pi_word_valid = 1'b1;
    while (!took && n < 2000) begin
      @(negedge clk);
      took = po_word_ready;
      @(posedge clk);
      #1;
      n++;
    end
    pi_word_valid = 1'b0;
    pi_keep_key = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL word_accept_timeout: got no transfer expected transfer of %h", w);
    end
  endtask

  task automatic send_block(input logic [127:0] b, input logic keep_first, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) idle(gap);
      send_word(b[127-32*i -: 32], (i == 0) ? keep_first : 1'b0);
    end
  endtask

  task automatic wait_start(output longint t);
    int n;
    n = 0;
    t = -1;
    while (n < 500) begin
      @(negedge clk);
      if (po_start) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no po_start expected one");
    end
  endtask

  task automatic wait_valid(output longint t);
    int n;
    n = 0;
    t = -1;
    while (n < 500) begin
      @(negedge clk);
      if (po_cipher_valid) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no po_cipher_valid expected one");
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, po_word_ready, 0);
    chk({tag, "_start"}, po_start, 0);
    chk({tag, "_busy"}, po_busy, 0);
    chk({tag, "_valid"}, po_cipher_valid, 0);
    chk({tag, "_cipher"}, po_cipher, 0);
    chk({tag, "_key"}, po_input_key, 0);
    chk({tag, "_data"}, po_input_data, 0);
  endtask

  // ---------------- test sequence ----------------
  longint ts, tv;
  int     s0;

  initial begin
    #1;
    chk_all_zero("reset");
    idle(3);
    pi_rst = 1'b0;

    // Basic FIPS-197 job.
    rmode = 1;
    s0 = starts;
    send_block(FK, 1'b0, 0);
    send_block(FD, 1'b0, 0);
    wait_start(ts);
    chk("basic_key", po_input_key, FK);
    chk("basic_data", po_input_data, FD);
    wait_valid(tv);
    chk("basic_latency", 128'(tv - ts), 128'(L + 1));
    chk("basic_cipher", po_cipher, FC);
    chk("basic_start_count", 128'(starts - s0), 128'(1));
    @(posedge clk);
    #1;

    // Backpressure, then a gapped job whose first word waits through DONE.
    rmode = 0;
    send_block(FK, 1'b0, 0);
    send_block(FD, 1'b0, 0);
    wait_valid(tv);
    @(posedge clk);
    #1;
    pi_word = FK[127:96];
    pi_word_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", po_cipher_valid, 1);
      chk("bp_ready", po_word_ready, 0);
      chk("bp_cipher", po_cipher, FC);
    end
    @(posedge clk);
    #1;
    rmode = 1;
    pi_cipher_ready = 1'b1;
    s0 = starts;
    send_word(FK[127:96], 1'b0);
    for (int i = 1; i < 4; i++) begin
      idle(3);
      send_word(FK[127-32*i -: 32], 1'b0);
    end
    idle(3);
    send_block(FD, 1'b0, 3);
    wait_start(ts);
    chk("gap_key", po_input_key, FK);
    chk("gap_data", po_input_data, FD);
    wait_valid(tv);
    chk("gap_cipher", po_cipher, FC);
    chk("gap_start_count", 128'(starts - s0), 128'(1));
    @(posedge clk);
    #1;

    // Key reuse: with the feature only the data group is sent.
`ifdef AES128_LOADER_KEY_REUSE_EN
    send_block(FD, 1'b1, 0);
`else
    send_block(FK, 1'b1, 0);
    send_block(FD, 1'b0, 0);
`endif
    wait_start(ts);
    chk("reuse_key", po_input_key, FK);
    wait_valid(tv);
    chk("reuse_cipher", po_cipher, FC);
    @(posedge clk);
    #1;

    // Reset in WAIT, then keep_key must be refused because the key is gone.
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
    wait_start(ts);
    idle(5);
    pi_rst = 1'b1;
    #1;
    chk_all_zero("rst_wait");
    @(posedge clk);
    #1;
    pi_rst = 1'b0;
    idle(L + 5);
    send_block(FK, 1'b1, 0);
    send_block(FD, 1'b0, 0);
    wait_valid(tv);
    chk("post_rst_key", po_input_key, FK);
    chk("post_rst_cipher", po_cipher, FC);
    @(posedge clk);
    #1;

    // Randomized word stream with random keep, gaps and consumer readiness.
    rmode = 2;
    for (int i = 0; i < 160; i++) begin
      send_word($urandom, 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end
    begin
      int n;
      n = 0;
      while ((t_start >= 0 || mq.size() != 0) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (t_start >= 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got job still pending expected idle");
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes128_block_loader.md
Name: aes128_block_loader

Overview:
- Front-end stage directly upstream of the AES-128 top level.
- Accepts key and plaintext as a stream of 32-bit words over a valid/ready handshake and assembles the 128-bit key and data buses that feed the core.
- Issues the core start pulse, waits a fixed core latency, captures the core's 128-bit output and presents it as a ciphertext with a valid/ready handshake.
- Only one block is in flight at a time.

Parameters:
- CORE_LATENCY, 44: cycles from the core start pulse (cycle 0) to the cycle in which the core output is sampled; must be >= 1.
- CNT_W, $clog2(CORE_LATENCY+1): width of the latency counter; derived, not overridden.

Ports:
- pi_clk  in  1  clock.
- pi_rst  in  1  asynchronous, active-high reset.
- pi_word  in  32  input word; within each 128-bit group, the first word maps to bits [127:96], the last to [31:0].
- pi_word_valid  in  1  pi_word is valid this cycle.
- po_word_ready  out  1  loader accepts pi_word this cycle.
- pi_keep_key  in  1  sampled with the first word of a job; key-reuse request (optional feature only).
- po_input_key  out  128  assembled key to the core.
- po_input_data  out  128  assembled plaintext to the core.
- po_start  out  1  one-cycle start pulse to the core.
- pi_core_out  in  128  core result bus.
- po_cipher  out  128  captured ciphertext.
- po_cipher_valid  out  1  po_cipher is valid.
- pi_cipher_ready  in  1  consumer accepts po_cipher.
- po_busy  out  1  high in START and WAIT.

Behaviour:
- Reset (asynchronous): every output is 0, all registers are 0, key_valid flag is 0, state is LOAD_KEY.
- A word transfer occurs when pi_word_valid && po_word_ready. po_word_ready = 1 only in LOAD_KEY and LOAD_DATA.
- The assembly shift register is shared: on each transfer, reg <= {reg[95:0], pi_word}. A 2-bit word counter tracks position within the group.
- LOAD_KEY:
  - On each transfer, shift into po_input_key.
  - On the 4th transfer: set key_valid, clear the counter, go to LOAD_DATA.
- LOAD_DATA:
  - On each transfer, shift into po_input_data.
  - On the 4th transfer: go to START.
- START:
  - po_start = 1 for exactly this cycle.
  - Latency counter loads 1.
  - Always go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - In the cycle counter == CORE_LATENCY: po_cipher <= pi_core_out, po_cipher_valid <= 1, go to DONE.
  - Total: the sample occurs CORE_LATENCY cycles after the po_start cycle.
- DONE:
  - po_cipher_valid is held high and po_cipher is held stable until pi_cipher_ready = 1.
  - On that cycle: po_cipher_valid <= 0, go to LOAD_KEY.
  - The earliest next-job word transfer is the following cycle.
- Stability: po_input_key and po_input_data change only on word transfers, so they are stable from START through DONE.
- po_cipher keeps its last value after the handshake.
- Boundary conditions:
  - pi_word_valid during START/WAIT/DONE: no transfer; the word is not consumed.
  - pi_word_valid deasserted mid-group: the counter holds; gaps of any length are allowed.
  - pi_cipher_ready high before DONE: ignored.
  - pi_cipher_ready high in the capture cycle: takes effect from the first DONE cycle (minimum valid pulse = 1 cycle).
  - Counter never wraps: CNT_W holds CORE_LATENCY.
  - pi_rst mid-job (any state): immediate return to reset values. key_valid is cleared and the in-flight job is discarded; no partial po_cipher_valid.

Optional Feature:
- Macro: AES128_LOADER_KEY_REUSE_EN.
- Defined:
  - In LOAD_KEY, if the first transfer of a job has pi_keep_key = 1 and key_valid = 1, that word is data word 0.
  - It is shifted into po_input_data, the counter is set to 1, and the state goes to LOAD_DATA.
  - po_input_key is unchanged. Only 4 words are needed for that job.
  - If key_valid = 0, pi_keep_key is ignored and the normal 8-word job runs.
- Undefined: pi_keep_key is ignored entirely; every job takes 8 words. The port remains present.

Decomposition:
- Shared package aes128_pkg:
  - State enum: LOAD_KEY, LOAD_DATA, START, WAIT, DONE.
  - AES_BLOCK_W = 128, AES_WORD_W = 32, WORDS_PER_BLOCK = 4.
- One natural sub-module: aes128_word_packer, the 32-to-128 shift register plus word counter with a group-complete flag, instantiated once and steered between key and data.
- FSM and latency counter stay in the top of this block.

Test Plan:
- Basic job (FIPS-197 vectors, bench loader plus core):
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data words 00112233, 44556677, 8899aabb, ccddeeff, with pi_cipher_ready = 1.
  - Required: po_input_key = 000102030405060708090a0b0c0d0e0f, one po_start pulse, and po_cipher = 69c4e0d86a7b0430d8cdb78070b4c55a exactly CORE_LATENCY+1 cycles after po_start.
- Backpressure:
  - Stimulus: hold pi_cipher_ready = 0 for 10 cycles after capture.
  - Required: po_cipher_valid stays high with po_cipher stable; po_word_ready stays 0; a word offered meanwhile is not consumed; cleared on the first ready cycle.
- Gapped input:
  - Stimulus: deassert pi_word_valid for 3 cycles between each word.
  - Required: the same assembled buses and result as the basic job, with no extra po_start.
- Reset in WAIT:
  - Stimulus: pulse pi_rst 5 cycles after po_start.
  - Required: all outputs 0 asynchronously, no po_cipher_valid, and a new 8-word job completes normally.
- Key reuse (macro defined):
  - Stimulus: after the basic job, send pi_keep_key = 1 with 4 data words 00112233 .. ccddeeff.
  - Required: po_start after the 4th word, po_input_key unchanged, and the same ciphertext.
- Key reuse rejected:
  - With the macro defined: pi_keep_key = 1 right after reset treats the first word as a key word, and 8 words are required.
  - With the macro undefined: pi_keep_key = 1 is always ignored.
